// File: rtl/ui_menu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ui_menu_ctrl
// Brief    : Front-panel button conditioning (sync, debounce, auto-repeat)
//            driving a DISPLAY/EDIT menu over NUM_ITEMS settings registers.
// Revision : 1.0
// ============================================================================
module ui_menu_ctrl #(
  parameter int                           NUM_ITEMS  = 5,
  parameter int                           VAL_W      = 3,
  parameter int                           SEL_W      = 3,
  parameter logic [NUM_ITEMS*VAL_W-1:0]   ITEM_MAX   = {NUM_ITEMS{3'd7}},
  parameter logic [NUM_ITEMS*VAL_W-1:0]   ITEM_RST   = '0,
  parameter logic [NUM_ITEMS-1:0]         WRAP_MASK  = '1,
  parameter int                           DEB_W      = 24,
  parameter int                           REP_START  = 25000000,
  parameter int                           REP_PERIOD = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 Button,
  output logic [NUM_ITEMS*VAL_W-1:0] values,
  output logic [SEL_W-1:0]           sel_item,
  output logic                       menu_active,
  output logic                       alt_mode,
  output logic                       repaint,
  output logic                       val_chg
);

  localparam int REP_MAXC = (REP_START > REP_PERIOD) ? REP_START : REP_PERIOD;
  localparam int REP_W    = $clog2(REP_MAXC + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_START - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_PERIOD - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_ITEMS - 1);

  localparam logic [0:0] ST_DISPLAY = 1'b0;
  localparam logic [0:0] ST_EDIT    = 1'b1;

  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, p_q, p_d;
  logic [1:0]       vld_q, vld_d;
  logic [DEB_W-1:0] lock_q [4];
  logic [DEB_W-1:0] lock_d [4];
  logic [3:2]       r_ev;

  // prev is forced high until the sync pipeline holds real samples, so a
  // button held through reset is not seen as a fresh rising edge.
  always_comb begin
    sync1_d = Button;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    prev_d  = vld_q[1] ? sync2_q : 4'hF;
    for (int k = 0; k < 4; k++) begin
      p_d[k] = sync2_q[k] & ~prev_q[k] & (lock_q[k] == '0);
      if (p_d[k])
        lock_d[k] = '1;
      else if (lock_q[k] != '0)
        lock_d[k] = lock_q[k] - DEB_W'(1);
      else
        lock_d[k] = lock_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '1;
      vld_q   <= '0;
      p_q     <= '0;
      for (int k = 0; k < 4; k++) lock_q[k] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      vld_q   <= vld_d;
      p_q     <= p_d;
      for (int k = 0; k < 4; k++) lock_q[k] <= lock_d[k];
    end
  end

  logic [0:0]                 state_q, state_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic                       alt_q, alt_d;
  logic [NUM_ITEMS*VAL_W-1:0] vals_q, vals_d;
  logic                       repaint_q, repaint_d;
  logic                       chg_q, chg_d;

  for (genvar k = 2; k < 4; k++) begin : g_rep
    logic [REP_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d, first_q, first_d, rep_q, rep_d;

    always_comb begin
      cnt_d   = cnt_q;
      run_d   = run_q;
      first_d = first_q;
      rep_d   = 1'b0;
      if (!sync2_q[k] || state_q != ST_EDIT) begin
        run_d   = 1'b0;
        cnt_d   = '0;
        first_d = 1'b1;
      end else if (p_d[k]) begin
        run_d   = 1'b1;
        cnt_d   = '0;
        first_d = 1'b1;
      end else if (run_q) begin
        if (cnt_q == (first_q ? REP_FIRST : REP_NEXT)) begin
          rep_d   = 1'b1;
          cnt_d   = '0;
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_q + REP_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        run_q   <= 1'b0;
        first_q <= 1'b1;
        rep_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        run_q   <= run_d;
        first_q <= first_d;
        rep_q   <= rep_d;
      end
    end

    assign r_ev[k] = rep_q;
  end

  logic [3:0]       ev;
  logic [VAL_W-1:0] cur, mx, nxt;

  // One action per cycle; the lowest-numbered event wins.
  always_comb begin
    ev        = p_q | {r_ev, 2'b00};
    state_d   = state_q;
    sel_d     = sel_q;
    alt_d     = alt_q;
    vals_d    = vals_q;
    repaint_d = 1'b0;
    chg_d     = 1'b0;
    cur       = '0;
    mx        = '0;
    nxt       = '0;
    if (ev[0]) begin
      repaint_d = 1'b1;
      if (state_q == ST_DISPLAY) begin
        state_d = ST_EDIT;
        sel_d   = '0;
      end else begin
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      end
    end else if (ev[1]) begin
      repaint_d = 1'b1;
      if (state_q == ST_DISPLAY) alt_d = ~alt_q;
      else                       state_d = ST_DISPLAY;
    end else if ((ev[2] | ev[3]) && state_q == ST_EDIT) begin
      repaint_d = 1'b1;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (sel_q == SEL_W'(i)) begin
          cur = vals_q[i*VAL_W +: VAL_W];
          mx  = ITEM_MAX[i*VAL_W +: VAL_W];
          if (ev[2])
            nxt = (cur >= mx) ? (WRAP_MASK[i] ? '0 : cur) : cur + VAL_W'(1);
          else
            nxt = (cur == '0) ? (WRAP_MASK[i] ? mx : cur) : cur - VAL_W'(1);
          vals_d[i*VAL_W +: VAL_W] = nxt;
          chg_d = (nxt != cur);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DISPLAY;
      sel_q     <= '0;
      alt_q     <= 1'b0;
      vals_q    <= ITEM_RST;
      repaint_q <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      alt_q     <= alt_d;
      vals_q    <= vals_d;
      repaint_q <= repaint_d;
      chg_q     <= chg_d;
    end
  end

  assign values      = vals_q;
  assign sel_item    = sel_q;
  assign menu_active = (state_q == ST_EDIT);
  assign alt_mode    = alt_q;
  assign repaint     = repaint_q;
  assign val_chg     = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_ui_menu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ui_menu_ctrl
// Brief    : Scoreboard bench for ui_menu_ctrl (3 items, short debounce/repeat).
// Revision : 1.0
// ============================================================================
module tb_ui_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Button = 4'b0000;
  logic [8:0] values;
  logic [1:0] sel_item;
  logic       menu_active, alt_mode, repaint, val_chg;

  ui_menu_ctrl #(
    .NUM_ITEMS (3),
    .VAL_W     (3),
    .SEL_W     (2),
    .ITEM_MAX  ({3'd2, 3'd7, 3'd5}),
    .ITEM_RST  (9'd0),
    .WRAP_MASK (3'b101),
    .DEB_W     (4),
    .REP_START (40),
    .REP_PERIOD(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Button     (Button),
    .values     (values),
    .sel_item   (sel_item),
    .menu_active(menu_active),
    .alt_mode   (alt_mode),
    .repaint    (repaint),
    .val_chg    (val_chg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       alt;
    logic       menu;
    logic [1:0] sel;
    logic [8:0] vals;
    logic       chg;
  } exp_t;

  exp_t exp_q[$];
  int   rp_t[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, rp_cnt = 0, chg_cnt = 0;

  // Reference model of the menu state
  logic m_alt = 1'b0, m_menu = 1'b0;
  int   m_sel = 0;
  int   m_val[3] = '{0, 0, 0};
  int   mx[3]    = '{5, 7, 2};
  bit   wr[3]    = '{1'b1, 1'b0, 1'b1};

  function automatic logic [8:0] m_pack();
    return {3'(m_val[2]), 3'(m_val[1]), 3'(m_val[0])};
  endfunction

  task automatic model_ev(input int k);
    exp_t e;
    int   old;
    e.chg = 1'b0;
    case (k)
      0: if (!m_menu) begin m_menu = 1'b1; m_sel = 0; end
         else m_sel = (m_sel == 2) ? 0 : m_sel + 1;
      1: if (!m_menu) m_alt = ~m_alt; else m_menu = 1'b0;
      default: if (m_menu) begin
        old = m_val[m_sel];
        if (k == 2) m_val[m_sel] = (old >= mx[m_sel]) ? (wr[m_sel] ? 0 : old) : old + 1;
        else        m_val[m_sel] = (old == 0) ? (wr[m_sel] ? mx[m_sel] : 0) : old - 1;
        e.chg = (m_val[m_sel] != old);
      end
    endcase
    e.alt  = m_alt;
    e.menu = m_menu;
    e.sel  = 2'(m_sel);
    e.vals = m_pack();
    exp_q.push_back(e);
  endtask

  task automatic press(input int k, input int hold, input int gap);
    @(posedge clk); #1 Button[k] = 1'b1;
    repeat (hold) @(posedge clk);
    #1 Button[k] = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  always @(posedge clk) cyc++;

  exp_t got, want;
  always @(negedge clk) begin
    if (!rst && val_chg === 1'b1) chg_cnt++;
    if (!rst && repaint === 1'b1) begin
      rp_cnt++;
      rp_t.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_repaint cycle %0d: got repaint=1, required no event", cyc);
      end else begin
        got  = {alt_mode, menu_active, sel_item, values, val_chg};
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: got alt=%0b menu=%0b sel=%0d vals=%h chg=%0b, required alt=%0b menu=%0b sel=%0d vals=%h chg=%0b",
                   cyc, got.alt, got.menu, got.sel, got.vals, got.chg,
                   want.alt, want.menu, want.sel, want.vals, want.chg);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({values, sel_item, menu_active, alt_mode, repaint, val_chg} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: got vals=%h sel=%0d menu=%0b alt=%0b rp=%0b chg=%0b, required all 0",
               values, sel_item, menu_active, alt_mode, repaint, val_chg);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_alt_lockout();
    int r0;
    r0 = rp_cnt;
    model_ev(1);
    @(posedge clk); #1 Button[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (repaint !== 1'b0) begin
      errors++; $display("FAIL alt_latency_early: got repaint=%0b, required 0", repaint);
    end
    @(negedge clk);
    checks++;
    if (repaint !== 1'b1 || alt_mode !== 1'b1) begin
      errors++; $display("FAIL alt_latency: got repaint=%0b alt=%0b, required 1 1", repaint, alt_mode);
    end
    @(posedge clk); #1 Button[1] = 1'b0;
    repeat (3) @(posedge clk); #1 Button[1] = 1'b1;
    repeat (5) @(posedge clk); #1 Button[1] = 1'b0;
    model_ev(1);
    repeat (7) @(posedge clk); #1 Button[1] = 1'b1;
    repeat (5) @(posedge clk); #1 Button[1] = 1'b0;
    repeat (25) @(posedge clk);
    checks++;
    if (rp_cnt - r0 !== 2 || alt_mode !== 1'b0) begin
      errors++; $display("FAIL lockout: got %0d repaints alt=%0b, required 2 and alt=0", rp_cnt - r0, alt_mode);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL alt_pending: got %0d outstanding, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_inc_wrap();
    int c0;
    model_ev(0);
    press(0, 5, 25);
    c0 = chg_cnt;
    for (int i = 0; i < 6; i++) begin
      model_ev(2);
      press(2, 5, 25);
    end
    repeat (5) @(posedge clk);
    checks++;
    if (chg_cnt - c0 !== 6) begin
      errors++; $display("FAIL inc_val_chg_count: got %0d, required 6", chg_cnt - c0);
    end
    checks++;
    if (values[2:0] !== 3'd0 || menu_active !== 1'b1) begin
      errors++; $display("FAIL inc_wrap: got item0=%0d menu=%0b, required 0 1", values[2:0], menu_active);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL inc_pending: got %0d outstanding, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_saturate();
    int c0, r0;
    model_ev(1); press(1, 5, 25);
    model_ev(0); press(0, 5, 25);
    model_ev(0); press(0, 5, 25);
    c0 = chg_cnt;
    r0 = rp_cnt;
    model_ev(3); press(3, 5, 25);
    checks++;
    if (rp_cnt - r0 !== 1 || chg_cnt !== c0) begin
      errors++; $display("FAIL saturate_pulses: got repaint=%0d val_chg=%0d, required 1 0", rp_cnt - r0, chg_cnt - c0);
    end
    checks++;
    if (values[5:3] !== 3'd0 || sel_item !== 2'd1) begin
      errors++; $display("FAIL saturate_value: got item1=%0d sel=%0d, required 0 1", values[5:3], sel_item);
    end
  endtask

  task automatic test_repeat();
    int c0, r0, d1, d2;
    c0 = chg_cnt;
    r0 = rp_t.size();
    for (int i = 0; i < 8; i++) model_ev(2);
    press(2, 105, 30);
    d1 = -1; d2 = -1;
    if (rp_t.size() >= r0 + 3) begin
      d1 = rp_t[r0 + 1] - rp_t[r0];
      d2 = rp_t[r0 + 2] - rp_t[r0 + 1];
    end
    checks++;
    if (d1 !== 40) begin
      errors++; $display("FAIL repeat_start: got %0d cycles, required 40", d1);
    end
    checks++;
    if (d2 !== 10) begin
      errors++; $display("FAIL repeat_period: got %0d cycles, required 10", d2);
    end
    checks++;
    if (chg_cnt - c0 !== 7 || values[5:3] !== 3'd7) begin
      errors++; $display("FAIL repeat_hold: got val_chg=%0d item1=%0d, required 7 7", chg_cnt - c0, values[5:3]);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL repeat_pending: got %0d outstanding, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_same_cycle();
    int c0;
    logic [8:0] v0;
    c0 = chg_cnt;
    v0 = m_pack();
    model_ev(0);
    @(posedge clk); #1 Button[0] = 1'b1; Button[2] = 1'b1;
    repeat (5) @(posedge clk); #1 Button[0] = 1'b0; Button[2] = 1'b0;
    repeat (25) @(posedge clk);
    checks++;
    if (sel_item !== 2'd2 || values !== v0 || chg_cnt !== c0) begin
      errors++; $display("FAIL priority: got sel=%0d vals=%h chg=%0d, required sel=2 vals=%h chg=0",
                         sel_item, values, chg_cnt - c0, v0);
    end
  endtask

  task automatic test_reset_mid_hold();
    int r0;
    model_ev(2);
    @(posedge clk); #1 Button[2] = 1'b1;
    repeat (5) @(posedge clk);
    model_ev(1);
    #1 Button[1] = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({values, sel_item, menu_active, alt_mode, repaint, val_chg} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got vals=%h sel=%0d menu=%0b alt=%0b rp=%0b chg=%0b, required all 0",
               values, sel_item, menu_active, alt_mode, repaint, val_chg);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL prereset_pending: got %0d outstanding, required 0", exp_q.size()); exp_q.delete();
    end
    m_alt = 1'b0; m_menu = 1'b0; m_sel = 0; m_val = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    r0 = rp_cnt;
    repeat (60) @(posedge clk);
    checks++;
    if (rp_cnt !== r0 || alt_mode !== 1'b0) begin
      errors++; $display("FAIL held_through_reset: got %0d repaints alt=%0b, required 0 0", rp_cnt - r0, alt_mode);
    end
    #1 Button[1] = 1'b0; Button[2] = 1'b0;
    repeat (5) @(posedge clk);
    model_ev(0); press(0, 5, 25);
    model_ev(2); press(2, 5, 25);
    checks++;
    if (values !== 9'd1 || menu_active !== 1'b1 || exp_q.size() !== 0) begin
      errors++; $display("FAIL after_reset: got vals=%h menu=%0b pending=%0d, required 001 1 0",
                         values, menu_active, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alt_lockout();
    test_inc_wrap();
    test_saturate();
    test_repeat();
    test_same_cycle();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ui_menu_ctrl.md
Name: ui_menu_ctrl

Overview:
- Parametrised front-panel controller: 4 push buttons are synchronised, debounced and turned into press events with hold-to-repeat. The events drive a DISPLAY/EDIT menu over NUM_ITEMS settings registers, each with its own maximum, wrap/saturate mode and reset value.
- Sits between the board buttons and the LCD text generator and DSP settings inputs. Generalises the fixed 5-item settings menu to N items with configurable ranges and auto-repeat.

Parameters:
- NUM_ITEMS, 5, number of settings registers (2..16)
- VAL_W, 3, width of each settings register (1..8)
- SEL_W, 3, width of sel_item; must satisfy 2**SEL_W >= NUM_ITEMS
- ITEM_MAX, {NUM_ITEMS{3'd7}}, packed per-item maximum; item i at [i*VAL_W +: VAL_W]
- ITEM_RST, 0, packed per-item reset value, same packing
- WRAP_MASK, all ones, bit i=1: item i wraps; bit i=0: item i saturates
- DEB_W, 24, debounce lockout lasts 2**DEB_W clk after an accepted press
- REP_START, 25000000, clk cycles of continuous hold before the first repeat
- REP_PERIOD, 5000000, clk cycles between subsequent repeats

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- Button  in  4  raw buttons: [0]=next/enter, [1]=exit/toggle, [2]=inc, [3]=dec
- values  out  NUM_ITEMS*VAL_W  packed settings registers
- sel_item  out  SEL_W  item being edited
- menu_active  out  1  1 while in EDIT
- alt_mode  out  1  display-mode toggle (e.g. mag/phase)
- repaint  out  1  one-cycle pulse: LCD content must be redrawn
- val_chg  out  1  one-cycle pulse: a value in values changed

Behaviour:
- Reset (async, rst=1): values=ITEM_RST, sel_item=0, menu_active=0, alt_mode=0, repaint=0, val_chg=0. Synchronisers, lockout counters and repeat counters are cleared. A reset mid-hold leaves no pending event; release is not required after reset.
- Sync: each Button bit passes through 2 flops, giving s[k].
- Press event p[k] asserts for 1 cycle when s[k] rises (previous sample 0) and lockout[k] is idle. It then loads lockout[k] with 2**DEB_W-1 and decrements it to 0. Rising edges during lockout are ignored.
- Latency: Button rise at edge N produces p at N+2 and the register/output update at N+3.
- Repeat (inc/dec only, EDIT only): the counter starts on p[k] and runs while s[k] stays 1.
  - At REP_START cycles after p it emits repeat event r[k].
  - It then emits r[k] every REP_PERIOD cycles.
  - s[k]=0 clears the counter. r[k] is not gated by lockout.
- Event e[k]=p[k]|r[k]. At most one action per cycle, priority 0>1>2>3; lower events in the same cycle are dropped.
- FSM DISPLAY (menu_active=0):
  - e0: go to EDIT, sel_item=0, repaint.
  - e1: alt_mode toggles, repaint.
  - e2/e3: ignored.
- FSM EDIT (menu_active=1):
  - e0: sel_item+1, wrapping from NUM_ITEMS-1 to 0, repaint.
  - e1: go to DISPLAY, sel_item held, repaint.
  - e2: inc item sel_item.
  - e3: dec item sel_item.
- Inc rules: at value==ITEM_MAX[i], wrap to 0 if WRAP_MASK[i]=1, else hold.
- Dec rules: at value==0, wrap to ITEM_MAX[i] if WRAP_MASK[i]=1, else hold.
- Any accepted e2/e3 in EDIT pulses repaint. val_chg pulses only if the value actually changed, so a saturated hold gives repaint=1, val_chg=0.
- repaint and val_chg are registered, 1 cycle wide, asserted in the same cycle the register updates.
- Values above ITEM_MAX can only come from ITEM_RST misconfiguration; inc then behaves as at-max.

Test Plan (DEB_W=4, REP_START=40, REP_PERIOD=10, NUM_ITEMS=3, VAL_W=3, ITEM_MAX={3'd2,3'd7,3'd5}, ITEM_RST=0, WRAP_MASK=3'b101):
- Reset then Button[1] pulse (5 clk) → alt_mode=1 and repaint pulse exactly 3 clk after rise. A second press 8 clk later is ignored; a press 20 clk after the first → alt_mode=0.
- Button[0], then Button[2] ×6 spaced 30 clk → menu_active=1, item0 goes 1..5 then wraps to 0. val_chg pulses 6 times.
- In EDIT, two Button[0] presses to select item1, then Button[3] once → item1 stays 0 (saturate), repaint=1, val_chg=0.
- Select item1, hold Button[2] 100 clk → item1=1 at press, then repeats at +40, +50, +60 … → value 7 and held at 7; val_chg stops at 7.
- Button[0] and Button[2] rise in the same cycle in EDIT → only sel_item advances; the value is unchanged.
- Hold Button[2], assert rst mid-hold then release rst → all outputs at reset values, and no event fires until a new rising edge.
